// File: rtl/hwpe_stream_tcdm_store.sv
// Stream-to-TCDM store stage: each stream beat becomes one TCDM write.
// The write address walks a 2D pattern: words inside a line, then lines.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               pulse that latches the config; only taken in IDLE
//   base_addr_i           byte address of the first word
//   word_stride_i         signed byte step between words of a line
//   line_stride_i         signed byte step between line start addresses
//   words_i, lines_i      words per line, number of lines
//   busy_o, done_o        busy in RUN/DONE; done is a 1-cycle end pulse
//   stream_*              HWPE stream sink (valid/ready/data/strb)
//   tcdm_*                TCDM master port, write-only
module hwpe_stream_tcdm_store #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH/8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [31:0]           word_stride_i,
  input  logic [31:0]           line_stride_i,
  input  logic [CNT_WIDTH-1:0]  words_i,
  input  logic [CNT_WIDTH-1:0]  lines_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  stream_valid_i,
  output logic                  stream_ready_o,
  input  logic [DATA_WIDTH-1:0] stream_data_i,
  input  logic [STRB_WIDTH-1:0] stream_strb_i,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [31:0]           tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [STRB_WIDTH-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0] tcdm_data_o,
  input  logic [31:0]           tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [31:0]          cur_addr_q;
  logic [31:0]          line_base_q;
  logic [31:0]          word_stride_q;
  logic [31:0]          line_stride_q;
  logic [CNT_WIDTH-1:0] words_q;
  logic [CNT_WIDTH-1:0] lines_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;
  logic [CNT_WIDTH-1:0] line_cnt_q;

  logic run;
  logic hs;
  logic last_word;
  logic last_line;
  logic zero_size;
  logic [31:0] next_line_base;

  // Read side of the TCDM port is never used by a store.
  logic unused_rd;
  assign unused_rd = ^{tcdm_r_data_i, tcdm_r_valid_i};

  assign run       = (state_q == RUN);
  assign hs        = run & stream_valid_i & tcdm_gnt_i;
  assign last_word = (word_cnt_q == words_q - ONE);
  assign last_line = (line_cnt_q == lines_q - ONE);
  assign zero_size = (words_i == '0) | (lines_i == '0);

  assign next_line_base = line_base_q + line_stride_q;

  // Zero-latency datapath: the request mirrors the stream directly,
  // and cur_addr only moves on a handshake, so a stalled request
  // stays stable until granted.
  assign tcdm_req_o     = run & stream_valid_i;
  assign stream_ready_o = run & tcdm_gnt_i;
  assign tcdm_add_o     = run ? cur_addr_q : 32'h0;
  assign tcdm_wen_o     = 1'b0;
  assign tcdm_be_o      = stream_strb_i;
  assign tcdm_data_o    = stream_data_i;

  assign busy_o = (state_q == RUN) | (state_q == DONE);
  assign done_o = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = zero_size ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs && last_word && last_line) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      line_base_q   <= '0;
      word_stride_q <= '0;
      line_stride_q <= '0;
      words_q       <= '0;
      lines_q       <= '0;
      word_cnt_q    <= '0;
      line_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        cur_addr_q    <= base_addr_i;
        line_base_q   <= base_addr_i;
        word_stride_q <= word_stride_i;
        line_stride_q <= line_stride_i;
        words_q       <= words_i;
        lines_q       <= lines_i;
        word_cnt_q    <= '0;
        line_cnt_q    <= '0;
      end else if (hs) begin
        if (!last_word) begin
          word_cnt_q <= word_cnt_q + ONE;
          cur_addr_q <= cur_addr_q + word_stride_q;
        end else begin
          // Line wrap restarts from the line base rather than
          // from the last word, so word and line strides are
          // independent.
          word_cnt_q  <= '0;
          line_cnt_q  <= line_cnt_q + ONE;
          line_base_q <= next_line_base;
          cur_addr_q  <= next_line_base;
        end
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_tcdm_store.sv
// Bench for hwpe_stream_tcdm_store: scoreboard of expected writes,
// one task per scenario.
module tb_hwpe_stream_tcdm_store;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] ws = '0;
  logic [31:0] ls = '0;
  logic [15:0] words = '0;
  logic [15:0] lines = '0;
  logic        busy;
  logic        done;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] sdata = '0;
  logic [3:0]  sstrb = '0;
  logic        req;
  logic        gnt = 1'b0;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] r_data = '0;
  logic        r_valid = 1'b0;

  int tests = 0;
  int fails = 0;

  beat_t sb[$];

  hwpe_stream_tcdm_store dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .base_addr_i    (base),
    .word_stride_i  (ws),
    .line_stride_i  (ls),
    .words_i        (words),
    .lines_i        (lines),
    .busy_o         (busy),
    .done_o         (done),
    .stream_valid_i (valid),
    .stream_ready_o (ready),
    .stream_data_i  (sdata),
    .stream_strb_i  (sstrb),
    .tcdm_req_o     (req),
    .tcdm_gnt_i     (gnt),
    .tcdm_add_o     (add),
    .tcdm_wen_o     (wen),
    .tcdm_be_o      (be),
    .tcdm_data_o    (wdata),
    .tcdm_r_data_i  (r_data),
    .tcdm_r_valid_i (r_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    beat_t e;
    if (req && gnt) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: add=%h data=%h, expected no write",
                 add, wdata);
      end else begin
        e = sb.pop_front();
        if ({add, wdata, be, wen} !== {e.addr, e.data, e.be, 1'b0}) begin
          fails++;
          $display("FAIL write: add=%h data=%h be=%b wen=%b, expected add=%h data=%h be=%b wen=0",
                   add, wdata, be, wen, e.addr, e.data, e.be);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] w_s,
                          input logic [31:0] l_s, input logic [15:0] nw,
                          input logic [15:0] nl);
    start = 1'b1;
    base  = b;
    ws    = w_s;
    ls    = l_s;
    words = nw;
    lines = nl;
    @(negedge clk);
    tests++;
    if ({busy, done, req} !== 3'b000) begin
      fails++;
      $display("FAIL start_idle: busy/done/req=%b, expected 000",
               {busy, done, req});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = 32'hDEAD_BEEF;
    ws    = 32'h1111_1111;
    ls    = 32'h2222_2222;
    words = 16'd7;
    lines = 16'd9;
  endtask

  task automatic run_xfer(input logic [31:0] b, input logic [31:0] w_s,
                          input logic [31:0] l_s, input int nw,
                          input int nl, input logic [3:0] st,
                          input int stall_beat, input int stall_len,
                          input bit poke, input int stop);
    beat_t exp[$];
    beat_t e;
    int n;
    int cyc;
    int want;
    n = nw * nl;
    cyc = 0;
    for (int l = 0; l < nl; l++) begin
      for (int w = 0; w < nw; w++) begin
        e.addr = b + 32'(l) * l_s + 32'(w) * w_s;
        e.data = $urandom;
        e.be   = st;
        exp.push_back(e);
        if (exp.size() <= stop) sb.push_back(e);
      end
    end
    gnt = 1'b1;
    do_start(b, w_s, l_s, 16'(nw), 16'(nl));
    for (int k = 0; k < stop; k++) begin
      valid = 1'b1;
      sdata = exp[k].data;
      sstrb = exp[k].be;
      start = poke && (k == 1);
      for (int c = 0; ; c++) begin
        gnt = !(k == stall_beat && c < stall_len);
        @(negedge clk);
        cyc++;
        if (!gnt) begin
          tests++;
          if ({req, ready, add, wdata} !==
              {1'b1, 1'b0, exp[k].addr, exp[k].data}) begin
            fails++;
            $display("FAIL stall: req=%b ready=%b add=%h data=%h, expected 1 0 %h %h",
                     req, ready, add, wdata, exp[k].addr, exp[k].data);
          end
        end
        if (req && gnt) break;
        if (c >= 64) begin
          tests++;
          fails++;
          $display("FAIL handshake_timeout: beat %0d req=%b, expected a write", k, req);
          valid = 1'b0;
          start = 1'b0;
          sb.delete();
          return;
        end
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    valid = 1'b0;
    if (stop < n) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      valid = 1'b1;
      gnt   = 1'b1;
      @(negedge clk);
      tests++;
      if ({req, busy, ready, done, add} !== '0) begin
        fails++;
        $display("FAIL reset_mid: req=%b busy=%b ready=%b done=%b add=%h, expected all 0",
                 req, busy, ready, done, add);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL reset_sb: %0d writes missing, expected 0", sb.size());
        sb.delete();
      end
      return;
    end
    @(negedge clk);
    tests++;
    if ({done, busy, req} !== 3'b110) begin
      fails++;
      $display("FAIL done_pulse: done/busy/req=%b, expected 110",
               {done, busy, req});
    end
    want = n + ((stall_beat < n) ? stall_len : 0);
    tests++;
    if (cyc !== want) begin
      fails++;
      $display("FAIL cycles: took %0d, expected %0d", cyc, want);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_left: %0d writes missing, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b1;
    gnt   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({req, ready, busy, done, add, wen} !== '0) begin
      fails++;
      $display("FAIL reset: req=%b ready=%b busy=%b done=%b add=%h wen=%b, expected all 0",
               req, ready, busy, done, add, wen);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
  endtask

  task automatic test_1d();
    run_xfer(32'h1000, 32'd4, 32'd0, 4, 1, 4'hF, 99, 0, 1'b0, 4);
  endtask

  task automatic test_stall();
    run_xfer(32'h1800, 32'd4, 32'd0, 4, 1, 4'hF, 1, 3, 1'b0, 4);
  endtask

  task automatic test_2d();
    run_xfer(32'h2000, 32'd4, 32'h100, 3, 2, 4'hF, 99, 0, 1'b1, 6);
  endtask

  task automatic test_zero(input logic [15:0] nw, input logic [15:0] nl);
    valid = 1'b1;
    gnt   = 1'b1;
    do_start(32'h5000, 32'd4, 32'd16, nw, nl);
    @(negedge clk);
    tests++;
    if ({busy, done, req, ready} !== 4'b1100) begin
      fails++;
      $display("FAIL zero_done: busy/done/req/ready=%b, expected 1100",
               {busy, done, req, ready});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({busy, done, req} !== 3'b000) begin
      fails++;
      $display("FAIL zero_idle: busy/done/req=%b, expected 000",
               {busy, done, req});
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_xfer(32'h6000, 32'd4, 32'd0, 8, 1, 4'hF, 99, 0, 1'b0, 2);
    run_xfer(32'h7000, 32'd8, 32'd0, 2, 1, 4'hA, 99, 0, 1'b0, 2);
  endtask

  task automatic test_wrap();
    run_xfer(32'h4, 32'hFFFF_FFFC, 32'd0, 3, 1, 4'b0101, 99, 0, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h8000, 32'd4, 32'h40, 2, 3, 4'hC, 2, 2, 1'b0, 6);
    run_xfer(32'h9000, 32'hFFFF_FFF0, 32'h20, 2, 2, 4'h3, 99, 0, 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_1d();
    test_stall();
    test_2d();
    test_zero(16'd4, 16'd0);
    test_zero(16'd0, 16'd3);
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
